// File: rtl/vector_write_sequencer.sv
// Result-side write sequencer: captures an issued vector op, waits out the FU
// latency, then streams one V-register write per element with chaining status.
module vector_write_sequencer #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned MAXLAT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_i,
  input  logic [6:0]       i_vl,
  input  logic [3:0]       i_latency,
  input  logic [WIDTH-1:0] i_result,
  output logic [7:0]       o_we,
  output logic [5:0]       o_addr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy,
  output logic             o_chain_ok,
  output logic             o_done
);

  localparam int unsigned LAT_W = $clog2(MAXLAT + 1);
  localparam int unsigned CNT_W = 7;
  localparam int unsigned MAXVL = 64;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         dest_q, dest_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [LAT_W-1:0]   wait_q, wait_d;
  logic [7:0]         we_q, we_d;
  logic [5:0]         addr_q, addr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic               chain_q, chain_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   vl_norm;
  logic [3:0]         lat_norm;

  // Length 0 and anything above 64 both mean a full 64-element vector.
  always_comb begin
    vl_norm  = (i_vl == 7'd0 || i_vl > CNT_W'(MAXVL)) ? CNT_W'(MAXVL) : i_vl;
    lat_norm = (i_latency == 4'd0) ? 4'd1 : i_latency;
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    count_d = count_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    chain_d = chain_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        chain_d = 1'b0;
        if (i_start) begin
          dest_d  = i_i;
          count_d = vl_norm;
          idx_d   = '0;
          wait_d  = LAT_W'(lat_norm - 4'd1);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          // Element 0 is on i_result this cycle; register it as the first write.
          we_d    = 8'(1) << dest_q;
          addr_d  = '0;
          data_d  = i_result;
          idx_d   = CNT_W'(1);
          chain_d = 1'b1;
          done_d  = (count_q == CNT_W'(1));
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q - LAT_W'(1);
        end
      end
      S_WRITE: begin
        if (idx_q < count_q) begin
          we_d   = 8'(1) << dest_q;
          addr_d = idx_q[5:0];
          data_d = i_result;
          idx_d  = idx_q + CNT_W'(1);
          done_d = (idx_q == count_q - CNT_W'(1));
        end else begin
          busy_d  = 1'b0;
          chain_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      chain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      chain_q <= chain_d;
      done_q  <= done_d;
    end
  end

  assign o_we       = we_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;
  assign o_chain_ok = chain_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_vector_write_sequencer.sv
// Directed bench for vector_write_sequencer: table of issues run back-to-back,
// plus hand sequences for reset behaviour and mid-sequence reset.
module tb_vector_write_sequencer;

  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic [2:0]       i_i = '0;
  logic [6:0]       i_vl = '0;
  logic [3:0]       i_latency = '0;
  logic [WIDTH-1:0] i_result = '0;
  logic [7:0]       o_we;
  logic [5:0]       o_addr;
  logic [WIDTH-1:0] o_data;
  logic             o_busy;
  logic             o_chain_ok;
  logic             o_done;

  vector_write_sequencer #(.WIDTH(WIDTH), .MAXLAT(15)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_i(i_i), .i_vl(i_vl),
    .i_latency(i_latency), .i_result(i_result), .o_we(o_we), .o_addr(o_addr),
    .o_data(o_data), .o_busy(o_busy), .o_chain_ok(o_chain_ok), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] i;
    logic [6:0] vl;
    logic [3:0] lat;
    int         n;      // expected normalised length
    int         l;      // expected normalised latency
    logic [7:0] we;     // expected one-hot write enable
    bit         poke;   // fire an ignored i_start (i_i=2) while busy
  } vec_t;

  vec_t tbl [8];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Advance one clock; sample/drive #1 after the edge. i_result = 0x100 + cycle.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    i_result = WIDTH'(64'h100 + 64'(cyc));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_we"}, 64'(o_we), 64'h0);
    check({tag, "_addr"}, 64'(o_addr), 64'h0);
    check({tag, "_data"}, o_data, 64'h0);
    check({tag, "_busy"}, 64'(o_busy), 64'h0);
    check({tag, "_chain"}, 64'(o_chain_ok), 64'h0);
    check({tag, "_done"}, 64'(o_done), 64'h0);
  endtask

  // Issue in the current cycle and check every cycle through the first idle one.
  task automatic run_seq(input vec_t v);
    int t;
    int d;
    bit wr;
    t = cyc;
    i_start = 1'b1; i_i = v.i; i_vl = v.vl; i_latency = v.lat;
    d = 0;
    while (d < v.l + v.n + 1) begin
      tick();
      d = cyc - t;
      wr = (d >= v.l + 1) && (d <= v.l + v.n);
      check("busy", 64'(o_busy), 64'(d <= v.l + v.n));
      check("we", 64'(o_we), wr ? 64'(v.we) : 64'h0);
      check("chain", 64'(o_chain_ok), 64'(wr));
      check("done", 64'(o_done), 64'(d == v.l + v.n));
      if (wr) begin
        check("addr", 64'(o_addr), 64'(d - v.l - 1));
        check("data", o_data, 64'h100 + 64'(cyc - 1));
      end
      if (v.poke && d == 3) begin
        i_start = 1'b1; i_i = 3'd2; i_vl = 7'd1; i_latency = 4'd1;
      end else begin
        i_start = 1'b0; i_i = 3'd0; i_vl = 7'd0; i_latency = 4'd0;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{i: 3'd5, vl: 7'd4,   lat: 4'd2,  n: 4,  l: 2,  we: 8'h20, poke: 1'b0};
    tbl[1] = '{i: 3'd0, vl: 7'd0,   lat: 4'd3,  n: 64, l: 3,  we: 8'h01, poke: 1'b0};
    tbl[2] = '{i: 3'd0, vl: 7'd100, lat: 4'd3,  n: 64, l: 3,  we: 8'h01, poke: 1'b0};
    tbl[3] = '{i: 3'd7, vl: 7'd1,   lat: 4'd0,  n: 1,  l: 1,  we: 8'h80, poke: 1'b0};
    tbl[4] = '{i: 3'd6, vl: 7'd8,   lat: 4'd1,  n: 8,  l: 1,  we: 8'h40, poke: 1'b1};
    tbl[5] = '{i: 3'd1, vl: 7'd64,  lat: 4'd15, n: 64, l: 15, we: 8'h02, poke: 1'b0};
    tbl[6] = '{i: 3'd4, vl: 7'd65,  lat: 4'd1,  n: 64, l: 1,  we: 8'h10, poke: 1'b0};
    tbl[7] = '{i: 3'd2, vl: 7'd1,   lat: 4'd1,  n: 1,  l: 1,  we: 8'h04, poke: 1'b0};

    #1 rst = 1'b0;
    #1 check_idle_zero("reset");
    tick(); tick();
    rst = 1'b1;
    while (cyc < 10) begin
      tick();
      check("idle_busy", 64'(o_busy), 64'h0);
      check("idle_we", 64'(o_we), 64'h0);
    end

    // Issue at cycle 10, then every later entry starts in the first idle cycle.
    for (int k = 0; k < 8; k++) run_seq(tbl[k]);

    // Mid-sequence reset: vl=10, L=1, i=3; third write (addr 2) lands at T+4.
    begin
      int t;
      t = cyc;
      i_start = 1'b1; i_i = 3'd3; i_vl = 7'd10; i_latency = 4'd1;
      tick(); i_start = 1'b0;
      while (cyc - t < 4) tick();
      check("pre_rst_addr", 64'(o_addr), 64'h2);
      check("pre_rst_we", 64'(o_we), 64'h08);
      #2 rst = 1'b0;
      #1 check_idle_zero("async_rst");
      tick(); check_idle_zero("rst_hold");
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        check("post_rst_we", 64'(o_we), 64'h0);
        check("post_rst_busy", 64'(o_busy), 64'h0);
      end
      run_seq('{i: 3'd1, vl: 7'd2, lat: 4'd1, n: 2, l: 1, we: 8'h02, poke: 1'b0});
      tick();
      check("final_we", 64'(o_we), 64'h0);
      check("final_busy", 64'(o_busy), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
